// File: rtl/i2c_pin_cond_pkg.sv
// Shared definitions for the I2C pin conditioning stage: default widths,
// line index constants and the registered bus-event bundle.
package i2c_pin_cond_pkg;

    localparam int FiltWDefault = 4;
    localparam int IdleWDefault = 16;

    localparam int SclIdx = 0;
    localparam int SdaIdx = 1;

    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } pin_events_t;

    // Classify one cycle of filtered line history into bus events.
    // START/STOP need SCL high both before and after, so a simultaneous
    // SCL+SDA change only reports the SCL edge.
    function automatic pin_events_t detect_events(
        input logic scl_prev,
        input logic scl_cur,
        input logic sda_prev,
        input logic sda_cur
    );
        pin_events_t ev;
        ev.scl_rise = ~scl_prev & scl_cur;
        ev.scl_fall = scl_prev & ~scl_cur;
        ev.start    = scl_prev & scl_cur & sda_prev & ~sda_cur;
        ev.stop     = scl_prev & scl_cur & ~sda_prev & sda_cur;
        return ev;
    endfunction

endpackage

// File: rtl/i2c_pin_cond_if.sv
// Bundle of pad inputs, filter configuration and conditioned outputs that
// connects the pin conditioning stage to the I2C core.
interface i2c_pin_cond_if
    import i2c_pin_cond_pkg::*;
#(
    parameter int FiltW = FiltWDefault,
    parameter int IdleW = IdleWDefault
);

    logic             cio_scl_i;
    logic             cio_sda_i;
    logic             filt_en_i;
    logic [FiltW-1:0] filt_cycles_i;
    logic [IdleW-1:0] idle_cycles_i;

    logic             scl_o;
    logic             sda_o;
    logic             scl_rise_o;
    logic             scl_fall_o;
    logic             start_det_o;
    logic             stop_det_o;
    logic             bus_busy_o;
    logic             glitch_o;

    modport slave (
        input  cio_scl_i, cio_sda_i, filt_en_i, filt_cycles_i, idle_cycles_i,
        output scl_o, sda_o, scl_rise_o, scl_fall_o,
               start_det_o, stop_det_o, bus_busy_o, glitch_o
    );

    modport master (
        output cio_scl_i, cio_sda_i, filt_en_i, filt_cycles_i, idle_cycles_i,
        input  scl_o, sda_o, scl_rise_o, scl_fall_o,
               start_det_o, stop_det_o, bus_busy_o, glitch_o
    );

endinterface

// File: rtl/i2c_pin_filter.sv
// Single-line glitch filter. A new level is accepted only after it has
// differed from the stable value for cycles_i+1 consecutive cycles; a
// candidate that disappears early produces a one-cycle glitch pulse.
module i2c_pin_filter
    import i2c_pin_cond_pkg::*;
#(
    parameter int FiltW = FiltWDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_i,
    input  logic             en_i,
    input  logic [FiltW-1:0] cycles_i,
    output logic             out_o,
    output logic             glitch_o
);

    logic             stab_q, stab_d;
    logic [FiltW-1:0] cnt_q,  cnt_d;

    // Track how long the input has disagreed with the stable value; using >=
    // lets a shrinking threshold commit on the very next differing cycle.
    always_comb begin
        stab_d = stab_q;
        cnt_d  = cnt_q;
        if (!en_i) begin
            stab_d = in_i;
            cnt_d  = '0;
        end else if (in_i == stab_q) begin
            cnt_d  = '0;
        end else if (cnt_q >= cycles_i) begin
            stab_d = in_i;
            cnt_d  = '0;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Stable level and disagreement counter, idle-bus reset state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stab_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            stab_q <= stab_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_o    = stab_q;
    assign glitch_o = en_i & (in_i == stab_q) & (cnt_q != '0);

endmodule

// File: rtl/i2c_pin_cond.sv
// I2C pad input conditioning: 2-flop synchroniser, optional fixed delay,
// per-line glitch filter, registered edge/START/STOP detection and a
// bus-busy flag with an optional idle timeout.
module i2c_pin_cond
    import i2c_pin_cond_pkg::*;
#(
    parameter int InputDelayCycles = 0,
    parameter int FiltW            = FiltWDefault,
    parameter int IdleW            = IdleWDefault
) (
    input logic           clk_i,
    input logic           rst_ni,
    i2c_pin_cond_if.slave bus
);

    logic [1:0]       sync_meta_q, sync_meta_d;
    logic [1:0]       sync_q,      sync_d;
    logic [1:0]       line_dly;

    logic             scl_f, sda_f;
    logic             scl_glitch, sda_glitch;

    logic             scl_prev_q, scl_prev_d;
    logic             sda_prev_q, sda_prev_d;
    pin_events_t      events_q,   events_d;
    logic             busy_q,     busy_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             both_high;
    logic             timeout;

    // Next state of the two synchroniser ranks for both lines.
    always_comb begin
        sync_meta_d         = sync_meta_q;
        sync_meta_d[SclIdx] = bus.cio_scl_i;
        sync_meta_d[SdaIdx] = bus.cio_sda_i;
        sync_d              = sync_meta_q;
    end

    // Synchroniser flops, reset to an idle (high) bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_meta_q <= 2'b11;
            sync_q      <= 2'b11;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
        end
    end

    if (InputDelayCycles == 0) begin : g_no_delay
        assign line_dly = sync_q;
    end else begin : g_delay
        logic [1:0] dly_q [InputDelayCycles];
        logic [1:0] dly_d [InputDelayCycles];

        // Shift the synchronised pair down the fixed delay line.
        always_comb begin
            dly_d[0] = sync_q;
            for (int i = 1; i < InputDelayCycles; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end

        // Delay line registers, reset to an idle (high) bus.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < InputDelayCycles; i++) begin
                    dly_q[i] <= 2'b11;
                end
            end else begin
                for (int i = 0; i < InputDelayCycles; i++) begin
                    dly_q[i] <= dly_d[i];
                end
            end
        end

        assign line_dly = dly_q[InputDelayCycles-1];
    end

    i2c_pin_filter #(
        .FiltW (FiltW)
    ) u_scl_filter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .in_i     (line_dly[SclIdx]),
        .en_i     (bus.filt_en_i),
        .cycles_i (bus.filt_cycles_i),
        .out_o    (scl_f),
        .glitch_o (scl_glitch)
    );

    i2c_pin_filter #(
        .FiltW (FiltW)
    ) u_sda_filter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .in_i     (line_dly[SdaIdx]),
        .en_i     (bus.filt_en_i),
        .cycles_i (bus.filt_cycles_i),
        .out_o    (sda_f),
        .glitch_o (sda_glitch)
    );

    assign both_high = scl_f & sda_f;

    // Decode events and update the busy flag; the idle counter only runs
    // while a transfer is open and both lines sit high, and saturates.
    always_comb begin
        scl_prev_d = scl_f;
        sda_prev_d = sda_f;
        events_d   = detect_events(scl_prev_q, scl_f, sda_prev_q, sda_f);
        busy_d     = busy_q;
        idle_cnt_d = '0;
        timeout    = 1'b0;

        if (busy_q && both_high) begin
            idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
            timeout    = (bus.idle_cycles_i != '0) &&
                         (idle_cnt_q >= bus.idle_cycles_i - 1'b1);
        end

        if (events_d.start) begin
            busy_d = 1'b1;
        end else if (events_d.stop) begin
            busy_d     = 1'b0;
            idle_cnt_d = '0;
        end else if (timeout) begin
            busy_d     = 1'b0;
            idle_cnt_d = '0;
        end
    end

    // Event, history and busy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            events_q   <= '0;
            busy_q     <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            events_q   <= events_d;
            busy_q     <= busy_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign bus.scl_o       = scl_f;
    assign bus.sda_o       = sda_f;
    assign bus.scl_rise_o  = events_q.scl_rise;
    assign bus.scl_fall_o  = events_q.scl_fall;
    assign bus.start_det_o = events_q.start;
    assign bus.stop_det_o  = events_q.stop;
    assign bus.bus_busy_o  = busy_q;
    assign bus.glitch_o    = scl_glitch | sda_glitch;

endmodule

// File: tb/tb_i2c_pin_cond.sv
// Directed bench for the I2C pin conditioning stage with hand-derived timing.
module tb_i2c_pin_cond;
    import i2c_pin_cond_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    i2c_pin_cond_if #(.FiltW(FiltWDefault), .IdleW(IdleWDefault)) bus_if ();

    i2c_pin_cond #(
        .InputDelayCycles (0),
        .FiltW            (FiltWDefault),
        .IdleW            (IdleWDefault)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    int rise_seen   = 0;
    int fall_seen   = 0;
    int start_seen  = 0;
    int stop_seen   = 0;
    int glitch_seen = 0;

    // Count every pulse seen out of reset so tests can compare deltas.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus_if.scl_rise_o  === 1'b1) rise_seen++;
            if (bus_if.scl_fall_o  === 1'b1) fall_seen++;
            if (bus_if.start_det_o === 1'b1) start_seen++;
            if (bus_if.stop_det_o  === 1'b1) stop_seen++;
            if (bus_if.glitch_o    === 1'b1) glitch_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus_if.scl_o, bus_if.sda_o, bus_if.scl_rise_o, bus_if.scl_fall_o,
                bus_if.start_det_o, bus_if.stop_det_o, bus_if.bus_busy_o, bus_if.glitch_o};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.cio_scl_i     = 1'b1;
        bus_if.cio_sda_i     = 1'b1;
        bus_if.filt_en_i     = 1'b1;
        bus_if.filt_cycles_i = 4'd3;
        bus_if.idle_cycles_i = 16'd0;
        tick(3);
        check_cnt++;
        if (outs() !== 8'hC0) $display("[TB] FAIL reset_hold: got %b expected %b", outs(), 8'hC0);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check_cnt++;
            if (outs() !== 8'hC0) $display("[TB] FAIL reset_idle[%0d]: got %b expected %b", i, outs(), 8'hC0);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        int g0 = glitch_seen;
        int s0 = start_seen;
        logic dropped = 1'b0;
        bus_if.cio_sda_i = 1'b0;
        tick(3);
        bus_if.cio_sda_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus_if.sda_o !== 1'b1) dropped = 1'b1;
        end
        check_cnt++;
        if (dropped !== 1'b0) $display("[TB] FAIL glitch_sda_dropped: got %b expected 0", dropped);
        else pass_cnt++;
        check_cnt++;
        if (glitch_seen - g0 !== 1) $display("[TB] FAIL glitch_pulses: got %0d expected 1", glitch_seen - g0);
        else pass_cnt++;
        check_cnt++;
        if (start_seen - s0 !== 0) $display("[TB] FAIL glitch_no_start: got %0d expected 0", start_seen - s0);
        else pass_cnt++;
    endtask

    task automatic test_start_stop();
        int s0 = start_seen;
        int p0 = stop_seen;
        int g0 = glitch_seen;
        bus_if.cio_sda_i = 1'b0;
        tick(5);
        check_cnt++;
        if (bus_if.sda_o !== 1'b1) $display("[TB] FAIL sda_before_latency: got %b expected 1", bus_if.sda_o);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if ({bus_if.sda_o, bus_if.start_det_o} !== 2'b00) $display("[TB] FAIL sda_fall_at_6: got %b expected 00", {bus_if.sda_o, bus_if.start_det_o});
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if ({bus_if.start_det_o, bus_if.bus_busy_o} !== 2'b11) $display("[TB] FAIL start_pulse_busy: got %b expected 11", {bus_if.start_det_o, bus_if.bus_busy_o});
        else pass_cnt++;
        tick(3);
        bus_if.cio_sda_i = 1'b1;
        tick(6);
        check_cnt++;
        if ({bus_if.sda_o, bus_if.stop_det_o, bus_if.bus_busy_o} !== 3'b101) $display("[TB] FAIL sda_rise_at_6: got %b expected 101", {bus_if.sda_o, bus_if.stop_det_o, bus_if.bus_busy_o});
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if ({bus_if.stop_det_o, bus_if.bus_busy_o} !== 2'b10) $display("[TB] FAIL stop_pulse_busy: got %b expected 10", {bus_if.stop_det_o, bus_if.bus_busy_o});
        else pass_cnt++;
        tick(2);
        check_cnt++;
        if ({start_seen - s0, stop_seen - p0, glitch_seen - g0} !== {32'd1, 32'd1, 32'd0}) $display("[TB] FAIL start_stop_counts: got %0d/%0d/%0d expected 1/1/0", start_seen - s0, stop_seen - p0, glitch_seen - g0);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        int f0, r0, s0, p0;
        bus_if.filt_en_i = 1'b0;
        tick(4);
        f0 = fall_seen; r0 = rise_seen; s0 = start_seen; p0 = stop_seen;
        bus_if.cio_scl_i = 1'b0;
        bus_if.cio_sda_i = 1'b0;
        tick(3);
        check_cnt++;
        if ({bus_if.scl_o, bus_if.sda_o} !== 2'b00) $display("[TB] FAIL nofilt_latency: got %b expected 00", {bus_if.scl_o, bus_if.sda_o});
        else pass_cnt++;
        tick(3);
        check_cnt++;
        if ({fall_seen - f0, start_seen - s0} !== {32'd1, 32'd0} || bus_if.bus_busy_o !== 1'b0) $display("[TB] FAIL same_cycle_fall: got fall %0d start %0d busy %b expected 1 0 0", fall_seen - f0, start_seen - s0, bus_if.bus_busy_o);
        else pass_cnt++;
        bus_if.cio_scl_i = 1'b1;
        bus_if.cio_sda_i = 1'b1;
        tick(6);
        check_cnt++;
        if ({rise_seen - r0, stop_seen - p0} !== {32'd1, 32'd0}) $display("[TB] FAIL same_cycle_rise: got rise %0d stop %0d expected 1 0", rise_seen - r0, stop_seen - p0);
        else pass_cnt++;
    endtask

    task automatic test_idle_timeout();
        int p0 = stop_seen;
        logic found = 1'b0;
        bus_if.idle_cycles_i = 16'd50;
        bus_if.cio_sda_i = 1'b0;
        tick(5);
        check_cnt++;
        if (bus_if.bus_busy_o !== 1'b1) $display("[TB] FAIL idle_start_busy: got %b expected 1", bus_if.bus_busy_o);
        else pass_cnt++;
        bus_if.cio_scl_i = 1'b0; tick(4);
        bus_if.cio_sda_i = 1'b1; tick(4);
        bus_if.cio_scl_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus_if.scl_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check_cnt++;
        if (found !== 1'b1) $display("[TB] FAIL idle_scl_high_timeout: got %b expected 1", found);
        else pass_cnt++;
        tick(49);
        check_cnt++;
        if (bus_if.bus_busy_o !== 1'b1) $display("[TB] FAIL busy_before_timeout: got %b expected 1", bus_if.bus_busy_o);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (bus_if.bus_busy_o !== 1'b0) $display("[TB] FAIL busy_at_timeout: got %b expected 0", bus_if.bus_busy_o);
        else pass_cnt++;
        check_cnt++;
        if (stop_seen - p0 !== 0) $display("[TB] FAIL timeout_no_stop: got %0d expected 0", stop_seen - p0);
        else pass_cnt++;

        bus_if.idle_cycles_i = 16'd0;
        bus_if.cio_sda_i = 1'b0; tick(5);
        bus_if.cio_scl_i = 1'b0; tick(4);
        bus_if.cio_sda_i = 1'b1; tick(4);
        bus_if.cio_scl_i = 1'b1;
        tick(200);
        check_cnt++;
        if (bus_if.bus_busy_o !== 1'b1) $display("[TB] FAIL busy_no_timeout: got %b expected 1", bus_if.bus_busy_o);
        else pass_cnt++;
        bus_if.cio_scl_i = 1'b0; tick(4);
        bus_if.cio_sda_i = 1'b0; tick(4);
        bus_if.cio_scl_i = 1'b1; tick(4);
        bus_if.cio_sda_i = 1'b1; tick(5);
        check_cnt++;
        if (bus_if.bus_busy_o !== 1'b0 || stop_seen - p0 !== 1) $display("[TB] FAIL idle_final_stop: got busy %b stops %0d expected 0 1", bus_if.bus_busy_o, stop_seen - p0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int s0 = start_seen;
        logic dropped = 1'b0;
        bus_if.cio_sda_i = 1'b0;
        tick(4);
        bus_if.cio_scl_i = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(1); if (bus_if.bus_busy_o !== 1'b1) dropped = 1'b1; end
        bus_if.cio_sda_i = 1'b1;
        for (int i = 0; i < 4; i++) begin tick(1); if (bus_if.bus_busy_o !== 1'b1) dropped = 1'b1; end
        bus_if.cio_scl_i = 1'b1;
        for (int i = 0; i < 4; i++) begin tick(1); if (bus_if.bus_busy_o !== 1'b1) dropped = 1'b1; end
        bus_if.cio_sda_i = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(1); if (bus_if.bus_busy_o !== 1'b1) dropped = 1'b1; end
        check_cnt++;
        if (start_seen - s0 !== 2) $display("[TB] FAIL rep_start_count: got %0d expected 2", start_seen - s0);
        else pass_cnt++;
        check_cnt++;
        if (dropped !== 1'b0) $display("[TB] FAIL rep_start_busy_drop: got %b expected 0", dropped);
        else pass_cnt++;

        bus_if.cio_scl_i = 1'b0;
        tick(2);
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (outs() !== 8'hC0) $display("[TB] FAIL reset_async_now: got %b expected %b", outs(), 8'hC0);
        else pass_cnt++;
        tick(3);
        check_cnt++;
        if (outs() !== 8'hC0) $display("[TB] FAIL reset_async_hold: got %b expected %b", outs(), 8'hC0);
        else pass_cnt++;
    endtask

    task automatic test_reset_release();
        int s0 = start_seen;
        int f0 = fall_seen;
        rst_n = 1'b1;
        tick(3);
        check_cnt++;
        if ({bus_if.scl_o, bus_if.sda_o} !== 2'b00) $display("[TB] FAIL release_low_latency: got %b expected 00", {bus_if.scl_o, bus_if.sda_o});
        else pass_cnt++;
        tick(3);
        check_cnt++;
        if ({start_seen - s0, fall_seen - f0} !== {32'd0, 32'd1} || bus_if.bus_busy_o !== 1'b0) $display("[TB] FAIL release_low_events: got start %0d fall %0d busy %b expected 0 1 0", start_seen - s0, fall_seen - f0, bus_if.bus_busy_o);
        else pass_cnt++;

        rst_n = 1'b0;
        bus_if.cio_scl_i = 1'b1;
        bus_if.cio_sda_i = 1'b0;
        tick(2);
        s0 = start_seen;
        rst_n = 1'b1;
        tick(4);
        check_cnt++;
        if (start_seen - s0 !== 1 || bus_if.bus_busy_o !== 1'b1) $display("[TB] FAIL release_sda_low_start: got start %0d busy %b expected 1 1", start_seen - s0, bus_if.bus_busy_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start_stop();
        test_same_cycle();
        test_idle_timeout();
        test_back_to_back();
        test_reset_release();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_pin_cond.md
Name: i2c_pin_cond

Overview:
Input conditioning stage between the SCL/SDA pads and the I2C controller/target core. It synchronises the raw pad inputs, adds an optional fixed delay, and rejects glitches with a programmable stability filter. It produces clean line levels, single-cycle edge and START/STOP event pulses, and a bus-busy flag for the core's state machines.

Parameters:
InputDelayCycles, 0, extra register stages after the synchroniser (0..8).
FiltW, 4, width of the glitch-filter cycle count.
IdleW, 16, width of the bus-idle timeout count.

Ports:
clk_i  in  1  block clock
rst_ni  in  1  reset; asynchronous assert, active-low
cio_scl_i  in  1  raw SCL pad input
cio_sda_i  in  1  raw SDA pad input
filt_en_i  in  1  glitch filter enable; 0 = pass synchronised values straight through
filt_cycles_i  in  FiltW  required stable cycles minus 1
idle_cycles_i  in  IdleW  bus-free timeout in cycles; 0 disables the timeout
scl_o  out  1  filtered SCL level
sda_o  out  1  filtered SDA level
scl_rise_o  out  1  one-cycle pulse on a filtered SCL 0->1 transition
scl_fall_o  out  1  one-cycle pulse on a filtered SCL 1->0 transition
start_det_o  out  1  one-cycle pulse on START or repeated START
stop_det_o  out  1  one-cycle pulse on STOP
bus_busy_o  out  1  high between START and STOP or timeout
glitch_o  out  1  one-cycle pulse when a pending transition on either line is abandoned

Behaviour:
- Reset values:
  - Synchroniser, delay and filter stages: 1 (idle bus).
  - scl_o and sda_o: 1.
  - All pulses and bus_busy_o: 0.
  - Counters: 0.
- Synchroniser: 2-flop prim_flop_2sync per line, reset value 1. Follow it with InputDelayCycles plain registers.
- Filter, one independent instance per line:
  - Holds a stable value `stab` and a saturating counter `cnt`.
  - If the input equals `stab`: cnt <= 0.
  - Otherwise, if cnt == filt_cycles_i: stab <= input and cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
  - glitch_o fires in the cycle the input returns to `stab` while cnt != 0. OR the two lines together.
  - Latency from the synchroniser output: filt_cycles_i + 1 cycles.
  - filt_en_i = 0: stab <= input every cycle (1 cycle), cnt held at 0, no glitch pulses.
  - A change to filt_cycles_i mid-count is used immediately. If cnt already exceeds the new value, the next differing cycle commits.
- Edge/event detection: compare the filtered lines with their registered previous values (prev reset = 1). Outputs are registered, so a pulse appears 1 cycle after the filtered change.
  - scl_rise/scl_fall: from SCL prev vs current.
  - start_det: SDA 1->0 while SCL prev = 1 and current = 1.
  - stop_det: SDA 0->1 while SCL prev = 1 and current = 1.
  - SCL and SDA changing in the same cycle produce no START/STOP; only the SCL edge pulse fires.
- bus_busy_o:
  - Set on start_det and clear on stop_det.
  - START during busy (repeated START) keeps it 1.
  - Idle timeout: a counter increments while both filtered lines are 1 and busy = 1, and resets otherwise. When it reaches idle_cycles_i (nonzero), busy clears and the counter resets.
  - The idle counter saturates and never wraps.
- Async reset mid-transfer returns every output to its reset value in the same cycle.
- After release, a line held low on the pad reaches scl_o/sda_o only after sync + delay + filter latency. No spurious START is produced at that point, because SCL prev = 1 and SDA may fall.
  - Exception: SDA low with SCL high after reset is legitimately reported as a START.

Decomposition:
- i2c_reg_pkg holds nothing new.
- Add i2c_pin_cond_pkg with:
  - FiltW/IdleW defaults
  - a typedef for the event bundle struct {scl_rise, scl_fall, start, stop}
- One natural sub-module, i2c_pin_filter (one line: counter, stable value, glitch pulse), instantiated twice.

Test Plan:
- Reset release with pads 1/1 -> scl_o = sda_o = 1, no pulses, bus_busy_o = 0 for 100 cycles.
- filt_en = 1, filt_cycles = 3, InputDelayCycles = 0, SDA low for 3 cycles then high -> sda_o stays 1 and glitch_o pulses once. Hold SDA low for 6 cycles -> sda_o falls 2+4 cycles after the pad change.
- SCL held 1, SDA 1->0 -> start_det_o pulse 1 cycle after sda_o falls and bus_busy_o = 1. Then SDA 0->1 -> stop_det_o pulse and bus_busy_o = 0.
- SCL and SDA driven low on the same pad cycle (filter off) -> scl_fall_o only, no start_det_o.
- START then both lines held high with idle_cycles = 50 -> bus_busy_o clears exactly 50 cycles after both filtered lines are high. With idle_cycles = 0 it stays 1.
- Repeated START (START, SCL toggles, START again), then assert reset mid-transfer -> both START pulses seen, busy never drops. During reset, all outputs are at reset values.
